// File: rtl/uart_sched_pkg.sv
// Shared types and reset constants for the UART TX scheduler slice.
package uart_sched_pkg;

  localparam int BYTE_W  = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam sched_state_t       STATE_RST   = IDLE;
  localparam logic [BYTE_W-1:0]  TX_DATA_RST = 8'h00;
  localparam logic [TIMER_W-1:0] TIMER_RST   = 8'h00;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational winner select: scans from ptr+1 upward modulo NREQ.
// With UART_TX_SCHED_PRIO0_EN defined, requester 0 overrides and the rotation covers 1..NREQ-1 only.
module uart_rr_pick
  import uart_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] rr_req;
  logic [PW-1:0]   idx;

  always_comb begin
    rr_req = req;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
`ifdef UART_TX_SCHED_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    // Walk from the farthest slot to the nearest so the first candidate after ptr is kept.
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (rr_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`ifdef UART_TX_SCHED_PRIO0_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX core among NREQ byte requesters; flags a core that never acknowledges a start.
// Define UART_TX_SCHED_PRIO0_EN to give requester 0 absolute priority (grants to 0 leave ptr alone).
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int START_TO = 16
) (
  input  logic                    clk_50M,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [BYTE_W*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    sched_busy,
  output logic                    err_to
);

  localparam int PW = $clog2(NREQ);

  sched_state_t       state, state_next;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      winner;
  logic [TIMER_W-1:0] timer;
  logic               found;
  logic               grant;
  logic               timeout;
  logic               release_own;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    timeout     = 1'b0;
    release_own = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          grant      = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TIMER_W'(START_TO - 1)) begin
          timeout     = 1'b1;
          release_own = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          release_own = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx_start is registered off LAUNCH so it never overlaps the ack pulse.
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      state    <= STATE_RST;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= TX_DATA_RST;
      owner    <= '0;
      err_to   <= 1'b0;
      timer    <= TIMER_RST;
      ptr      <= PW'(NREQ - 1);
    end else begin
      state    <= state_next;
      ack      <= grant ? (NREQ'(1) << winner) : '0;
      tx_start <= (state == LAUNCH);
      err_to   <= timeout;
      if (grant) begin
        tx_data <= req_data[winner*BYTE_W +: BYTE_W];
        owner   <= winner;
      end
      if (state == LAUNCH) begin
        timer <= TIMER_RST;
      end else if (state == WAIT_BUSY && !tx_busy) begin
        timer <= timer + TIMER_W'(1);
      end
      if (release_own) begin
`ifdef UART_TX_SCHED_PRIO0_EN
        if (owner != '0) begin
          ptr <= owner;
        end
`else
        ptr <= owner;
`endif
      end
    end
  end

  assign sched_busy = (state != IDLE);

endmodule
